// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: operating mode,
// read-source selection and the placement of the memory-mapped registers
// at the top of the word-address space.
package dmem_pkg;

   // LOAD: host owns the RAM, core held in reset. RUN: core owns the RAM.
   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } mode_t;

   // Which source feeds the core read data for an accepted read.
   typedef enum logic [1:0] {
      SEL_RAM     = 2'd0,
      SEL_CYCLE   = 2'd1,
      SEL_CONSOLE = 2'd2
   } rd_sel_t;

   // Special registers, given as distance below the all-ones word address.
   localparam int unsigned CYCLE_ADDR_OFS   = 32'd1;
   localparam int unsigned CONSOLE_ADDR_OFS = 32'd0;

   // Width of the occupancy field in the console status word.
   localparam int unsigned CON_COUNT_W = 32'd9;

   // Console status word as seen by the core: overflow flag above occupancy.
   function automatic logic [31:0] con_status(input logic overflow,
                                              input logic [CON_COUNT_W-1:0] count);
      return {22'h000000, overflow, count};
   endfunction

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO that carries console output from the core to the host sink.
// A push into a full FIFO is accepted only when a pop frees a slot on the
// same edge; a pop from an empty FIFO is a no-op, so push+pop while empty
// simply enqueues (no fall-through).
module console_fifo
   import dmem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [7:0]       store_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             full_s;
   logic             empty_s;
   logic             do_push_s;
   logic             do_pop_s;
   logic [7:0]       head_s;

   // Occupancy flags and the actual push/pop decisions for this edge.
   always_comb begin
      full_s    = (count_r == CNT_W'(DEPTH));
      empty_s   = (count_r == CNT_W'(0));
      do_pop_s  = pop & ~empty_s;
      do_push_s = push & (~full_s | do_pop_s);
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**PTR_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Byte storage; contents are don't-care while empty so no reset needed.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         store_r[wr_ptr_r] <= push_data;
      end
   end

   // Head byte, forced to zero while empty so stale data never shows.
   always_comb begin
      head_s = 8'h00;
      if (empty_s) begin
         head_s = 8'h00;
      end else begin
         head_s = store_r[rd_ptr_r];
      end
   end

   assign full  = full_s;
   assign empty = empty_s;
   assign count = count_r;
   assign head  = head_s;

endmodule

// File: rtl/dmem_responder.sv
// Data memory for a soft core: a host loads the program image while the core
// is held in LOAD, then ld_done releases the core (RUN). In RUN the core sees
// a read-first RAM plus two registers at the top of the address space: a free
// running cycle counter and a console byte port backed by a FIFO.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_BITS  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   input  logic                 RE1,
   input  logic [ADDR_BITS-1:0] RA1,
   output logic [31:0]          RD1,
   input  logic [ADDR_BITS-1:0] WA2,
   input  logic [31:0]          WD2,
   input  logic                 WE2,
   input  logic                 ld_valid,
   input  logic [ADDR_BITS-1:0] ld_addr,
   input  logic [31:0]          ld_data,
   output logic                 ld_ready,
   input  logic                 ld_done,
   output logic                 run,
   output logic                 con_valid,
   output logic [7:0]           con_data,
   input  logic                 con_ready,
   output logic                 con_overflow
);

   localparam int WORDS = 1 << ADDR_BITS;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [ADDR_BITS-1:0] ALL_ONES     = {ADDR_BITS{1'b1}};
   localparam logic [ADDR_BITS-1:0] CYCLE_ADDR   = ALL_ONES - ADDR_BITS'(CYCLE_ADDR_OFS);
   localparam logic [ADDR_BITS-1:0] CONSOLE_ADDR = ALL_ONES - ADDR_BITS'(CONSOLE_ADDR_OFS);

   // Mode FSM
   mode_t                mode_r;
   mode_t                mode_next_s;
   logic                 ld_ready_s;
   logic                 run_s;

   // Address decode and datapath control
   rd_sel_t              rd_sel_s;
   rd_sel_t              wr_sel_s;
   logic                 core_re_s;
   logic                 ram_re_s;
   logic                 ram_we_s;
   logic [ADDR_BITS-1:0] ram_waddr_s;
   logic [31:0]          ram_wdata_s;
   logic                 push_s;
   logic                 pop_s;

   // Storage and registers
   logic [31:0]          ram_r [WORDS];
   logic [31:0]          ram_q_r;
   rd_sel_t              rd_sel_r;
   logic [31:0]          rd_special_r;
   logic [31:0]          rd1_s;
   logic [31:0]          cycle_r;
   logic                 con_overflow_r;

   // Console FIFO interface
   logic                 fifo_full_s;
   logic                 fifo_empty_s;
   logic [CNT_W-1:0]     fifo_count_s;
   logic [7:0]           fifo_head_s;
   logic [CON_COUNT_W-1:0] fifo_count9_s;

   // Mode state register; only reset leaves RUN.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         mode_r <= LOAD;
      end else begin
         mode_r <= mode_next_s;
      end
   end

   // Mode next-state: ld_done releases the core, RUN is terminal.
   always_comb begin
      mode_next_s = mode_r;
      case (mode_r)
         LOAD: begin
            if (ld_done) begin
               mode_next_s = RUN;
            end else begin
               mode_next_s = LOAD;
            end
         end
         RUN:     mode_next_s = RUN;
         default: mode_next_s = LOAD;
      endcase
   end

   // Mode outputs decoded from the state register.
   always_comb begin
      ld_ready_s = 1'b1;
      run_s      = 1'b0;
      case (mode_r)
         LOAD: begin
            ld_ready_s = 1'b1;
            run_s      = 1'b0;
         end
         RUN: begin
            ld_ready_s = 1'b0;
            run_s      = 1'b1;
         end
         default: begin
            ld_ready_s = 1'b1;
            run_s      = 1'b0;
         end
      endcase
   end

   // Classify the core read and write addresses.
   always_comb begin
      rd_sel_s = SEL_RAM;
      if (RA1 == CYCLE_ADDR) begin
         rd_sel_s = SEL_CYCLE;
      end else if (RA1 == CONSOLE_ADDR) begin
         rd_sel_s = SEL_CONSOLE;
      end else begin
         rd_sel_s = SEL_RAM;
      end
      wr_sel_s = SEL_RAM;
      if (WA2 == CYCLE_ADDR) begin
         wr_sel_s = SEL_CYCLE;
      end else if (WA2 == CONSOLE_ADDR) begin
         wr_sel_s = SEL_CONSOLE;
      end else begin
         wr_sel_s = SEL_RAM;
      end
   end

   // Route writes: the loader owns the RAM in LOAD, the core in RUN.
   // Core writes to the counter are dropped, console writes become pushes.
   always_comb begin
      ram_we_s    = 1'b0;
      ram_waddr_s = ld_addr;
      ram_wdata_s = ld_data;
      push_s      = 1'b0;
      if (run_s) begin
         ram_waddr_s = WA2;
         ram_wdata_s = WD2;
         if (WE2) begin
            case (wr_sel_s)
               SEL_RAM: begin
                  ram_we_s = 1'b1;
                  push_s   = 1'b0;
               end
               SEL_CONSOLE: begin
                  ram_we_s = 1'b0;
                  push_s   = 1'b1;
               end
               default: begin
                  ram_we_s = 1'b0;
                  push_s   = 1'b0;
               end
            endcase
         end else begin
            ram_we_s = 1'b0;
            push_s   = 1'b0;
         end
      end else begin
         ram_we_s    = ld_valid & ld_ready_s;
         ram_waddr_s = ld_addr;
         ram_wdata_s = ld_data;
         push_s      = 1'b0;
      end
   end

   // Core reads are honoured only in RUN; otherwise RD1 holds.
   always_comb begin
      core_re_s     = run_s & RE1;
      ram_re_s      = core_re_s & (rd_sel_s == SEL_RAM);
      pop_s         = ~fifo_empty_s & con_ready;
      fifo_count9_s = CON_COUNT_W'(fifo_count_s);
   end

   // RAM write port; contents deliberately survive reset.
   always_ff @(posedge CLOCK) begin
      if (ram_we_s) begin
         ram_r[ram_waddr_s] <= ram_wdata_s;
      end
   end

   // RAM synchronous read port; non-blocking read gives read-first behaviour.
   always_ff @(posedge CLOCK) begin
      if (ram_re_s) begin
         ram_q_r <= ram_r[RA1];
      end
   end

   // Remember the source of the last accepted read and capture register data.
   // Reset selects the (zeroed) register path so RD1 reads as zero.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         rd_sel_r     <= SEL_CYCLE;
         rd_special_r <= 32'h0000_0000;
      end else if (core_re_s) begin
         rd_sel_r <= rd_sel_s;
         case (rd_sel_s)
            SEL_CYCLE:   rd_special_r <= cycle_r;
            SEL_CONSOLE: rd_special_r <= con_status(con_overflow_r, fifo_count9_s);
            default:     rd_special_r <= rd_special_r;
         endcase
      end
   end

   // RD1 selects between the RAM output register and the register capture.
   always_comb begin
      rd1_s = rd_special_r;
      if (rd_sel_r == SEL_RAM) begin
         rd1_s = ram_q_r;
      end else begin
         rd1_s = rd_special_r;
      end
   end

   // Cycle counter: held at zero in LOAD, counts every RUN cycle and wraps.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         cycle_r <= 32'h0000_0000;
      end else if (run_s) begin
         cycle_r <= cycle_r + 32'h0000_0001;
      end else begin
         cycle_r <= 32'h0000_0000;
      end
   end

   // Sticky overflow: set when a push is dropped on a full FIFO.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         con_overflow_r <= 1'b0;
      end else if (push_s & fifo_full_s & ~pop_s) begin
         con_overflow_r <= 1'b1;
      end
   end

   console_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_console_fifo (
      .clk       (CLOCK),
      .rst_n     (RESET),
      .push      (push_s),
      .push_data (WD2[7:0]),
      .pop       (pop_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s),
      .head      (fifo_head_s)
   );

   assign RD1          = rd1_s;
   assign ld_ready     = ld_ready_s;
   assign run          = run_s;
   assign con_valid    = ~fifo_empty_s;
   assign con_data     = fifo_head_s;
   assign con_overflow = con_overflow_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed load/run/counter sequences, a table of
// RUN-mode vectors for RAM hazards and console FIFO corners, a mid-RUN reset,
// and randomized traffic checked against a queue/array reference model.
module tb_dmem_responder;

   localparam int AB    = 16;
   localparam int DEPTH = 4;
   localparam logic [AB-1:0] CYC = 16'hFFFE;
   localparam logic [AB-1:0] CON = 16'hFFFF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          RE1;
   logic [AB-1:0] RA1;
   logic [31:0]   RD1;
   logic [AB-1:0] WA2;
   logic [31:0]   WD2;
   logic          WE2;
   logic          ld_valid;
   logic [AB-1:0] ld_addr;
   logic [31:0]   ld_data;
   logic          ld_ready;
   logic          ld_done;
   logic          run;
   logic          con_valid;
   logic [7:0]    con_data;
   logic          con_ready;
   logic          con_overflow;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_BITS(AB), .FIFO_DEPTH(DEPTH)) dut (
      .CLOCK(clk), .RESET(rst_n), .RE1(RE1), .RA1(RA1), .RD1(RD1),
      .WA2(WA2), .WD2(WD2), .WE2(WE2),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ready(ld_ready), .ld_done(ld_done), .run(run),
      .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
      .con_overflow(con_overflow)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit          m_run;
   logic [31:0] m_ram [int];
   byte unsigned m_q [$];
   bit          m_ovf;
   logic [31:0] m_cyc;
   logic [31:0] m_rd;

   typedef struct {
      logic          re1;
      logic [AB-1:0] ra1;
      logic          we2;
      logic [AB-1:0] wa2;
      logic [31:0]   wd2;
      logic          cr;
      logic [31:0]   e_rd;
      logic          e_cv;
      logic [7:0]    e_cd;
      logic          e_ovf;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(logic re1, logic [AB-1:0] ra1, logic we2, logic [AB-1:0] wa2,
                               logic [31:0] wd2, logic cr, logic [31:0] e_rd, logic e_cv,
                               logic [7:0] e_cd, logic e_ovf);
      vec_t v;
      v.re1 = re1; v.ra1 = ra1; v.we2 = we2; v.wa2 = wa2; v.wd2 = wd2; v.cr = cr;
      v.e_rd = e_rd; v.e_cv = e_cv; v.e_cd = e_cd; v.e_ovf = e_ovf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(logic [AB-1:0] a);
      if (a == CYC) return m_cyc;
      if (a == CON) return {22'd0, m_ovf, 9'(m_q.size())};
      if (m_ram.exists(int'(a))) return m_ram[int'(a)];
      return 32'hxxxxxxxx;
   endfunction

   task automatic model_reset();
      m_run = 1'b0;
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 32'd0;
      m_rd  = 32'd0;
   endtask

   // One clock edge of the behavioural model, using the inputs present at that edge.
   task automatic model_edge();
      bit popped;
      int sz;
      sz = m_q.size();
      popped = (sz > 0) && con_ready;
      if (!m_run) begin
         if (ld_valid) m_ram[int'(ld_addr)] = ld_data;
         if (popped) void'(m_q.pop_front());
         if (ld_done) m_run = 1'b1;
      end else begin
         if (RE1) m_rd = m_read(RA1);
         if (popped) void'(m_q.pop_front());
         if (WE2) begin
            if (WA2 == CON) begin
               if (sz == DEPTH && !popped) m_ovf = 1'b1;
               else m_q.push_back(WD2[7:0]);
            end else if (WA2 != CYC) begin
               m_ram[int'(WA2)] = WD2;
            end
         end
         m_cyc = m_cyc + 32'd1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      RE1 = 1'b0; RA1 = '0; WE2 = 1'b0; WA2 = '0; WD2 = 32'd0;
      ld_valid = 1'b0; ld_addr = '0; ld_data = 32'd0; ld_done = 1'b0; con_ready = 1'b0;
   endtask

   task automatic check_model(input string tag);
      logic [31:0] e_cd;
      e_cd = (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0;
      chk({tag, " RD1"}, RD1, m_rd);
      chk({tag, " run"}, run, m_run);
      chk({tag, " ld_ready"}, ld_ready, !m_run);
      chk({tag, " con_valid"}, con_valid, m_q.size() > 0);
      chk({tag, " con_data"}, con_data, e_cd);
      chk({tag, " con_overflow"}, con_overflow, m_ovf);
   endtask

   function automatic logic [AB-1:0] pick_rd();
      int r;
      r = $urandom_range(0, 5);
      if (r == 0) return CYC;
      if (r == 1) return CON;
      return AB'($urandom_range(3, 15));
   endfunction

   function automatic logic [AB-1:0] pick_wr();
      int r;
      r = $urandom_range(0, 5);
      if (r == 0) return CYC;
      if (r <= 2) return CON;
      return AB'($urandom_range(6, 15));
   endfunction

   task automatic random_phase(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         RE1       = 1'($urandom_range(0, 1));
         RA1       = pick_rd();
         WE2       = 1'($urandom_range(0, 1));
         WA2       = pick_wr();
         WD2       = $urandom;
         con_ready = ($urandom_range(0, 3) == 0);
         ld_valid  = 1'($urandom_range(0, 1));
         ld_addr   = AB'($urandom_range(0, 15));
         ld_data   = $urandom;
         ld_done   = 1'($urandom_range(0, 1));
         step();
         check_model("rand");
      end
      idle();
   endtask

   initial begin
      // RUN-mode vector table: RAM hazard, console fill/overflow/drain corners.
      tbl[0]  = mk(1'b1, 16'h0005, 1'b1, 16'h0005, 32'h11111111, 1'b0, 32'h22222222, 1'b0, 8'h00, 1'b0);
      tbl[1]  = mk(1'b1, 16'h0005, 1'b0, 16'h0000, 32'h00000000, 1'b0, 32'h11111111, 1'b0, 8'h00, 1'b0);
      tbl[2]  = mk(1'b0, 16'h0000, 1'b1, CON,      32'h00000041, 1'b0, 32'h11111111, 1'b1, 8'h41, 1'b0);
      tbl[3]  = mk(1'b0, 16'h0000, 1'b1, CON,      32'h00000042, 1'b0, 32'h11111111, 1'b1, 8'h41, 1'b0);
      tbl[4]  = mk(1'b0, 16'h0000, 1'b1, CON,      32'h00000043, 1'b0, 32'h11111111, 1'b1, 8'h41, 1'b0);
      tbl[5]  = mk(1'b0, 16'h0000, 1'b1, CON,      32'h00000044, 1'b0, 32'h11111111, 1'b1, 8'h41, 1'b0);
      tbl[6]  = mk(1'b0, 16'h0000, 1'b1, CON,      32'h00000045, 1'b0, 32'h11111111, 1'b1, 8'h41, 1'b1);
      tbl[7]  = mk(1'b1, CON,      1'b0, 16'h0000, 32'h00000000, 1'b0, 32'h00000204, 1'b1, 8'h41, 1'b1);
      tbl[8]  = mk(1'b0, 16'h0000, 1'b1, CON,      32'h00000050, 1'b1, 32'h00000204, 1'b1, 8'h42, 1'b1);
      tbl[9]  = mk(1'b1, CON,      1'b0, 16'h0000, 32'h00000000, 1'b0, 32'h00000204, 1'b1, 8'h42, 1'b1);
      tbl[10] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 32'h00000000, 1'b1, 32'h00000204, 1'b1, 8'h43, 1'b1);
      tbl[11] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 32'h00000000, 1'b1, 32'h00000204, 1'b1, 8'h44, 1'b1);
      tbl[12] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 32'h00000000, 1'b1, 32'h00000204, 1'b1, 8'h50, 1'b1);
      tbl[13] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 32'h00000000, 1'b1, 32'h00000204, 1'b0, 8'h00, 1'b1);
      tbl[14] = mk(1'b0, 16'h0000, 1'b1, CON,      32'h00000060, 1'b1, 32'h00000204, 1'b1, 8'h60, 1'b1);
      tbl[15] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 32'h00000000, 1'b1, 32'h00000204, 1'b0, 8'h00, 1'b1);
      tbl[16] = mk(1'b1, 16'h0003, 1'b1, CYC,      32'hFFFFFFFF, 1'b0, 32'hDEADBEEF, 1'b0, 8'h00, 1'b1);
      tbl[17] = mk(1'b1, 16'h0005, 1'b0, 16'h0000, 32'h00000000, 1'b0, 32'h11111111, 1'b0, 8'h00, 1'b1);

      // Reset state
      idle();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset run", run, 32'd0);
      chk("reset ld_ready", ld_ready, 32'd1);
      chk("reset RD1", RD1, 32'd0);
      chk("reset con_valid", con_valid, 32'd0);
      chk("reset con_data", con_data, 32'd0);
      chk("reset con_overflow", con_overflow, 32'd0);
      rst_n = 1'b1;

      // Load image; core traffic during LOAD must be ignored, last word with ld_done
      for (int a = 0; a < 16; a++) begin
         ld_valid = 1'b1;
         ld_addr  = AB'(a);
         ld_data  = (a == 3) ? 32'hDEADBEEF : (a == 5) ? 32'h22222222 : $urandom;
         ld_done  = (a == 15);
         RE1 = 1'b1; RA1 = 16'h0003; WE2 = 1'b1; WA2 = 16'h0003; WD2 = 32'h0BAD0BAD;
         step();
         if (a == 7) begin
            chk("load ld_ready", ld_ready, 32'd1);
            chk("load run", run, 32'd0);
            chk("load RD1 hold", RD1, 32'd0);
         end
      end
      idle();
      chk("enter run", run, 32'd1);
      chk("enter ld_ready", ld_ready, 32'd0);
      chk("enter RD1 hold", RD1, 32'd0);

      // Cycle counter read at the 10th edge after entering RUN
      repeat (9) step();
      RE1 = 1'b1; RA1 = CYC;
      step();
      chk("cycle at +10", RD1, 32'd9);
      RE1 = 1'b0;
      step();
      chk("RD1 hold RE1=0", RD1, 32'd9);

      // Loader traffic in RUN is ignored
      ld_valid = 1'b1; ld_addr = 16'h0003; ld_data = 32'h0;
      RE1 = 1'b1; RA1 = 16'h0003;
      step();
      chk("read addr3", RD1, 32'hDEADBEEF);
      idle();
      RE1 = 1'b1; RA1 = 16'h0003;
      step();
      chk("addr3 after run-load", RD1, 32'hDEADBEEF);
      idle();

      // Table-driven RUN vectors
      for (int i = 0; i < 18; i++) begin
         RE1 = tbl[i].re1; RA1 = tbl[i].ra1; WE2 = tbl[i].we2; WA2 = tbl[i].wa2;
         WD2 = tbl[i].wd2; con_ready = tbl[i].cr;
         step();
         chk($sformatf("vec%0d RD1", i), RD1, tbl[i].e_rd);
         chk($sformatf("vec%0d con_valid", i), con_valid, 32'(tbl[i].e_cv));
         chk($sformatf("vec%0d con_data", i), con_data, 32'(tbl[i].e_cd));
         chk($sformatf("vec%0d con_overflow", i), con_overflow, 32'(tbl[i].e_ovf));
      end
      idle();

      // Reset mid-RUN with bytes queued
      WE2 = 1'b1; WA2 = CON; WD2 = 32'h77;
      step();
      WD2 = 32'h78;
      step();
      idle();
      chk("queued before reset", con_valid, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrun reset run", run, 32'd0);
      chk("midrun reset ld_ready", ld_ready, 32'd1);
      chk("midrun reset con_valid", con_valid, 32'd0);
      chk("midrun reset con_data", con_data, 32'd0);
      chk("midrun reset overflow", con_overflow, 32'd0);
      chk("midrun reset RD1", RD1, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      chk("reload-free LOAD", run, 32'd0);
      ld_done = 1'b1;
      step();
      idle();
      chk("rerun", run, 32'd1);
      RE1 = 1'b1; RA1 = CYC;
      step();
      chk("counter restarted", RD1, 32'd0);
      RA1 = 16'h0003;
      step();
      chk("RAM3 retained", RD1, 32'hDEADBEEF);
      RA1 = 16'h0005;
      step();
      chk("RAM5 retained", RD1, 32'h11111111);
      idle();
      step();
      check_model("post-reset");

      // Randomized traffic against the reference model
      random_phase(400);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
